// File: rtl/osd_dii_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : osd_dii_pkg / osd_dii_rr_arbiter_if
//  Description : DII flit type and the bundled port set of the round-robin
//                DII arbiter (N input flit ports, one output flit port).
//  Revision    : 1.0 - initial release
// ============================================================================

package osd_dii_pkg;
    // One DII flit as it travels on a debug port.
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

interface osd_dii_rr_arbiter_if #(
    parameter int N = 2
) ();
    import osd_dii_pkg::*;

    dii_flit [N-1:0] debug_in;
    logic    [N-1:0] debug_in_ready;
    dii_flit         debug_out;
    logic            debug_out_ready;
    logic    [N-1:0] grant;
    logic            pkt_len_err;

    // Side that drives the sources and the downstream ready.
    modport master (
        output debug_in,
        output debug_out_ready,
        input  debug_in_ready,
        input  debug_out,
        input  grant,
        input  pkt_len_err
    );

    // The arbiter itself.
    modport slave (
        input  debug_in,
        input  debug_out_ready,
        output debug_in_ready,
        output debug_out,
        output grant,
        output pkt_len_err
    );
endinterface

`default_nettype wire

// File: rtl/osd_dii_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : osd_dii_rr_arbiter
//  Description : Packet-atomic round-robin arbiter merging N DII flit sources
//                onto one output port. The grant is locked from the first
//                flit of a packet until its last flit is accepted; a flit
//                counter pulses pkt_len_err on packets above MAX_PKT_LEN.
//  Revision    : 1.0 - initial release
// ============================================================================

module osd_dii_rr_arbiter #(
    parameter int N           = 2,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    osd_dii_rr_arbiter_if.slave  bus
);
    import osd_dii_pkg::*;

    localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int c_CNT_W = $clog2(MAX_PKT_LEN + 1);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(MAX_PKT_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_ERR  = c_CNT_W'(MAX_PKT_LEN - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(N - 1);

    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_owner;
    logic [c_IDX_W-1:0] r_last_grant;
    logic [c_CNT_W-1:0] r_flit_cnt;
    logic               r_pkt_len_err;

    logic               w_found;
    logic [c_IDX_W-1:0] w_winner;
    logic [c_IDX_W-1:0] w_cand;
    logic [c_IDX_W-1:0] w_sel;
    logic               w_active;
    logic               w_xfer;
    dii_flit            w_flit;

    // Index of the source k positions after base, wrapping at N.
    function automatic logic [c_IDX_W-1:0] rr_idx(input logic [c_IDX_W-1:0] base,
                                                   input int k);
        return c_IDX_W'((int'(base) + k) % N);
    endfunction

    // Round-robin search starting just after the last granted source; the
    // loop runs from lowest to highest priority so the nearest valid wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = N; k >= 1; k--) begin
            w_cand = rr_idx(r_last_grant, k);
            if (bus.debug_in[w_cand].valid) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Output steering: the locked owner, else the fresh winner; silent in reset.
    always_comb begin
        w_sel    = (r_state == c_LOCKED) ? r_owner : w_winner;
        w_active = !rst && ((r_state == c_LOCKED) || w_found);
        w_flit   = bus.debug_in[w_sel];
        w_xfer   = w_active && w_flit.valid && bus.debug_out_ready;

        bus.debug_out      = w_active ? w_flit : '0;
        bus.grant          = '0;
        bus.debug_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_active && (w_sel == c_IDX_W'(i))) begin
                bus.grant[i]          = 1'b1;
                bus.debug_in_ready[i] = bus.debug_out_ready;
            end
        end
    end

    assign bus.pkt_len_err = r_pkt_len_err;

    // Lock/unlock state machine, round-robin pointer and packet length check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_owner       <= '0;
            r_last_grant  <= c_LAST_RST;
            r_flit_cnt    <= '0;
            r_pkt_len_err <= 1'b0;
        end else begin
            // The MAX_PKT_LEN-th flit without last marks the packet too long;
            // the saturating counter never returns to this value in-packet.
            r_pkt_len_err <= w_xfer && !w_flit.last && (r_flit_cnt == c_CNT_ERR);

            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        if (w_xfer && w_flit.last) begin
                            r_last_grant <= w_winner;
                            r_flit_cnt   <= '0;
                        end else begin
                            // Lock even without a transfer so the presented
                            // flit cannot switch source under backpressure.
                            r_state    <= c_LOCKED;
                            r_owner    <= w_winner;
                            r_flit_cnt <= w_xfer ? c_CNT_W'(1) : '0;
                        end
                    end
                end
                c_LOCKED: begin
                    if (w_xfer) begin
                        if (w_flit.last) begin
                            r_state      <= c_IDLE;
                            r_last_grant <= r_owner;
                            r_flit_cnt   <= '0;
                        end else if (r_flit_cnt != c_CNT_MAX) begin
                            r_flit_cnt <= r_flit_cnt + c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_osd_dii_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osd_dii_rr_arbiter
//  Description : Self-checking bench for osd_dii_rr_arbiter (N=2,
//                MAX_PKT_LEN=4): directed vector table followed by random
//                traffic compared against a packet-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_osd_dii_rr_arbiter;
    import osd_dii_pkg::*;

    localparam int N           = 2;
    localparam int MAX_PKT_LEN = 4;
    localparam int RAND_CYCLES = 3000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    osd_dii_rr_arbiter_if #(.N(N)) bus ();

    osd_dii_rr_arbiter #(
        .N           (N),
        .MAX_PKT_LEN (MAX_PKT_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        ordy;
        logic [1:0]  v;
        logic [1:0]  l;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        ev;
        logic        el;
        logic [15:0] ed;
        logic [1:0]  erdy;
        logic [1:0]  egnt;
        logic        eerr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic o, logic [1:0] v, logic [1:0] l,
                                logic [15:0] d0, logic [15:0] d1,
                                logic ev, logic el, logic [15:0] ed,
                                logic [1:0] erdy, logic [1:0] egnt, logic eerr);
        vec_t t;
        t.rst = r; t.ordy = o; t.v = v; t.l = l; t.d0 = d0; t.d1 = d1;
        t.ev = ev; t.el = el; t.ed = ed; t.erdy = erdy; t.egnt = egnt; t.eerr = eerr;
        return t;
    endfunction

    // Packs every observable output: {valid, last, data, ready[1:0], grant[1:0], err}.
    function automatic logic [22:0] pack(logic v, logic l, logic [15:0] d,
                                         logic [1:0] rdy, logic [1:0] g, logic e);
        return {v, l, d, rdy, g, e};
    endfunction

    function automatic logic [22:0] observe();
        return pack(bus.debug_out.valid, bus.debug_out.last, bus.debug_out.data,
                    bus.debug_in_ready, bus.grant, bus.pkt_len_err);
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got v=%b l=%b d=%h rdy=%b gnt=%b err=%b, expected v=%b l=%b d=%h rdy=%b gnt=%b err=%b",
                     name, act[22], act[21], act[20:5], act[4:3], act[2:1], act[0],
                     exp[22], exp[21], exp[20:5], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic drive(input logic r, input logic o, input logic [1:0] v, input logic [1:0] l,
                         input logic [15:0] d0, input logic [15:0] d1);
        rst                      = r;
        bus.debug_out_ready      = o;
        bus.debug_in[0].valid    = v[0];
        bus.debug_in[0].last     = l[0];
        bus.debug_in[0].data     = d0;
        bus.debug_in[1].valid    = v[1];
        bus.debug_in[1].last     = l[1];
        bus.debug_in[1].data     = d1;
    endtask

    // Reference model state: packet-level view of who owns the port.
    bit m_locked;
    int m_owner;
    int m_last;
    int m_flits;
    bit m_err;

    // Random source state.
    bit          s_v[N];
    bit          s_l[N];
    logic [15:0] s_d[N];
    int          s_rem[N];
    int          s_seq[N];

    initial begin
        logic [1:0]  rv, rl, erdy, egnt;
        logic [15:0] rd[N];
        logic [15:0] ed;
        logic        rr, ro, ev, el, xfer;
        int          sel;

        // Directed table: rows apply one per cycle, expectations derived by hand.
        // Single 3-flit packet on in0, zero latency.
        vq.push_back(mk(1,1,2'b11,2'b00,16'hA001,16'hB001, 0,0,16'h0000,2'b00,2'b00,0));
        vq.push_back(mk(1,1,2'b11,2'b00,16'hA001,16'hB001, 0,0,16'h0000,2'b00,2'b00,0));
        vq.push_back(mk(0,1,2'b01,2'b00,16'hA001,16'h0000, 1,0,16'hA001,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b01,2'b00,16'hA002,16'h0000, 1,0,16'hA002,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b01,2'b01,16'hA003,16'h0000, 1,1,16'hA003,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b00,2'b00,16'h0000,16'h0000, 0,0,16'h0000,2'b00,2'b00,0));
        // Contention from reset with 2-flit packets: in0,in0,in1,in1,in0,in0.
        vq.push_back(mk(1,1,2'b11,2'b00,16'hA011,16'hB011, 0,0,16'h0000,2'b00,2'b00,0));
        vq.push_back(mk(0,1,2'b11,2'b00,16'hA011,16'hB011, 1,0,16'hA011,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b11,2'b01,16'hA012,16'hB011, 1,1,16'hA012,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b11,2'b00,16'hA021,16'hB011, 1,0,16'hB011,2'b10,2'b10,0));
        vq.push_back(mk(0,1,2'b11,2'b10,16'hA021,16'hB012, 1,1,16'hB012,2'b10,2'b10,0));
        vq.push_back(mk(0,1,2'b11,2'b00,16'hA021,16'hB021, 1,0,16'hA021,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b11,2'b01,16'hA022,16'hB021, 1,1,16'hA022,2'b01,2'b01,0));
        // Backpressure in IDLE, in1 arrives while in0 is held, then late requester.
        vq.push_back(mk(0,0,2'b01,2'b00,16'hA031,16'h0000, 1,0,16'hA031,2'b00,2'b01,0));
        vq.push_back(mk(0,0,2'b11,2'b10,16'hA031,16'hB031, 1,0,16'hA031,2'b00,2'b01,0));
        vq.push_back(mk(0,0,2'b11,2'b10,16'hA031,16'hB031, 1,0,16'hA031,2'b00,2'b01,0));
        vq.push_back(mk(0,0,2'b11,2'b10,16'hA031,16'hB031, 1,0,16'hA031,2'b00,2'b01,0));
        vq.push_back(mk(0,1,2'b11,2'b10,16'hA031,16'hB031, 1,0,16'hA031,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b11,2'b11,16'hA032,16'hB031, 1,1,16'hA032,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b10,2'b10,16'h0000,16'hB031, 1,1,16'hB031,2'b10,2'b10,0));
        // 6-flit packet: one error pulse the cycle after the 4th flit.
        vq.push_back(mk(0,1,2'b01,2'b00,16'hA041,16'h0000, 1,0,16'hA041,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b01,2'b00,16'hA042,16'h0000, 1,0,16'hA042,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b01,2'b00,16'hA043,16'h0000, 1,0,16'hA043,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b01,2'b00,16'hA044,16'h0000, 1,0,16'hA044,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b01,2'b00,16'hA045,16'h0000, 1,0,16'hA045,2'b01,2'b01,1));
        vq.push_back(mk(0,1,2'b01,2'b01,16'hA046,16'h0000, 1,1,16'hA046,2'b01,2'b01,0));
        // 4-flit packet with a bubble and a competing in1: no pulse, no switch.
        vq.push_back(mk(0,1,2'b01,2'b00,16'hA051,16'h0000, 1,0,16'hA051,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b01,2'b00,16'hA052,16'h0000, 1,0,16'hA052,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b10,2'b10,16'h0000,16'hB051, 0,0,16'h0000,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b11,2'b10,16'hA053,16'hB051, 1,0,16'hA053,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b11,2'b11,16'hA054,16'hB051, 1,1,16'hA054,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b10,2'b10,16'h0000,16'hB051, 1,1,16'hB051,2'b10,2'b10,0));
        // Reset in the middle of an in1 packet; in0 wins first afterwards.
        vq.push_back(mk(0,1,2'b10,2'b00,16'h0000,16'hB061, 1,0,16'hB061,2'b10,2'b10,0));
        vq.push_back(mk(0,1,2'b10,2'b00,16'h0000,16'hB062, 1,0,16'hB062,2'b10,2'b10,0));
        vq.push_back(mk(1,1,2'b11,2'b00,16'hA071,16'hB063, 0,0,16'h0000,2'b00,2'b00,0));
        vq.push_back(mk(0,1,2'b11,2'b00,16'hA071,16'hB063, 1,0,16'hA071,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b11,2'b01,16'hA072,16'hB063, 1,1,16'hA072,2'b01,2'b01,0));
        vq.push_back(mk(0,1,2'b10,2'b00,16'h0000,16'hB063, 1,0,16'hB063,2'b10,2'b10,0));

        // Clear the registers once before any output is judged.
        drive(1'b1, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0);
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].ordy, vq[i].v, vq[i].l, vq[i].d0, vq[i].d1);
            #1;
            check($sformatf("vec%0d", i), observe(),
                  pack(vq[i].ev, vq[i].el, vq[i].ed, vq[i].erdy, vq[i].egnt, vq[i].eerr));
            @(posedge clk);
            #1;
        end

        // Random traffic against the packet-level model.
        for (int i = 0; i < N; i++) begin
            s_v[i] = 0; s_l[i] = 0; s_d[i] = '0; s_rem[i] = 0; s_seq[i] = 0;
        end
        m_locked = 0; m_owner = 0; m_last = N - 1; m_flits = 0; m_err = 0;

        for (int c = 0; c < RAND_CYCLES; c++) begin
            rr = (c < 2) || ($urandom_range(0, 299) == 0);
            ro = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (rr) begin
                    s_v[i] = 0; s_rem[i] = 0;
                end else if (!s_v[i] && ($urandom_range(0, 2) == 0)) begin
                    if (s_rem[i] == 0) s_rem[i] = $urandom_range(1, 6);
                    s_v[i] = 1;
                    s_l[i] = (s_rem[i] == 1);
                    s_d[i] = {4'(i), 12'(s_seq[i])};
                    s_seq[i]++;
                end
                rv[i] = s_v[i];
                rl[i] = s_v[i] ? s_l[i] : 1'b0;
                rd[i] = s_v[i] ? s_d[i] : 16'h0000;
            end
            drive(rr, ro, rv, rl, rd[0], rd[1]);
            #1;

            // Who presents this cycle: the packet owner, else the next
            // requester after the last finished source, wrapping around.
            sel = -1;
            if (!rr) begin
                if (m_locked) begin
                    sel = m_owner;
                end else begin
                    for (int k = N; k >= 1; k--)
                        if (rv[(m_last + k) % N]) sel = (m_last + k) % N;
                end
            end
            ev = 0; el = 0; ed = '0; erdy = '0; egnt = '0;
            if (sel >= 0) begin
                ev        = rv[sel];
                el        = rl[sel];
                ed        = rd[sel];
                egnt[sel] = 1'b1;
                erdy[sel] = ro;
            end
            xfer = ev && ro;
            check($sformatf("rand%0d", c), observe(), pack(ev, el, ed, erdy, egnt, m_err));

            @(posedge clk);
            #1;

            if (rr) begin
                m_locked = 0; m_owner = 0; m_last = N - 1; m_flits = 0; m_err = 0;
            end else begin
                m_err = xfer && !el && (m_flits + 1 == MAX_PKT_LEN);
                if (sel >= 0) begin
                    if (xfer && el) begin
                        m_locked = 0;
                        m_last   = sel;
                        m_flits  = 0;
                    end else begin
                        m_locked = 1;
                        m_owner  = sel;
                        if (xfer) m_flits++;
                    end
                end
                if (xfer) begin
                    s_v[sel] = 0;
                    s_rem[sel]--;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
